fft_se2pa_stream: RTL and testbench
===================================

# fft_se2pa_stream

Parametrised serial-to-parallel converter at the front of the pipelined FFT. It gathers `LANES` consecutive complex samples from a one-sample-per-beat stream into a single wide word for the radix engine. Lane placement is natural or bit-reversed, selectable per group. The output is held under a valid/ready handshake, with back-pressure propagated to the source.

## Interface

- `NB`, 16, sample width of each real/imag component
- `LANES`, 4, samples per output word; power of two, 2..32
- `GW`, 8, width of the group counter `OUT_GRP`
- `CLK` in 1: clock, rising edge
- `RST` in 1: reset, asynchronous, active-low
- `START` in 1: synchronous frame restart, single-cycle pulse
- `BR` in 1: lane order for the group being started; 0 = natural, 1 = bit-reversed
- `IN_VLD` in 1: `DR`/`DI` valid
- `IN_RDY` out 1: block can accept a sample this cycle
- `DR`, `DI` in `NB`: real/imag input sample
- `OUT_VLD` out 1: `OR`/`OI`/`OUT_GRP` valid
- `OUT_RDY` in 1: consumer accepts the output word
- `OR`, `OI` out `NB*LANES`: lane j occupies bits `[NB*j +: NB]`; lane 0 is at the LSBs
- `OUT_GRP` out `GW`: group index since last `START` or reset; wraps modulo 2^GW

## Operation

- Accept means `IN_VLD && IN_RDY` at a rising edge.
- Sample counter `cnt` (log2(LANES) bits) counts accepted samples within the current group.
- Samples 0..LANES-2 are written into a collect buffer. Sample k goes to lane k (natural) or lane bitrev(k) over log2(LANES) bits (bit-reversed).
- `BR` is sampled only when sample 0 of a group is accepted. It is held internally for that whole group. Changes to `BR` mid-group are ignored.
- When sample LANES-1 is accepted:
  - The collect buffer plus the current sample is loaded into `OR`/`OI` in one step, using the same lane mapping.
  - `OUT_VLD` is set and `OUT_GRP` receives the group counter.
  - The group counter increments and `cnt` wraps to 0.
- `IN_RDY = START | !(cnt == LANES-1 && OUT_VLD && !OUT_RDY)`. Only the closing sample stalls, and only while an undelivered word is held. Samples 0..LANES-2 are always accepted.
- Output hold: `OUT_VLD` clears on `OUT_VLD && OUT_RDY` unless a new word loads on the same edge. In that case `OUT_VLD` stays 1 and the data is replaced. While `OUT_VLD && !OUT_RDY`, `OR`/`OI`/`OUT_GRP` are stable.
- `START`:
  - Clears `cnt` and the group counter and discards any partial group.
  - Does not touch `OR`/`OI`/`OUT_VLD`/`OUT_GRP`; a held word remains deliverable.
  - If `IN_VLD` is high in the same cycle, that sample is accepted as sample 0 of the new group, with `BR` sampled then. `START` wins over any stall.
- Reset values:
  - `cnt` = 0, group counter = 0, held mode = natural.
  - `OUT_VLD` = 0, `OR`/`OI` = 0, `OUT_GRP` = 0.
  - `IN_RDY` = 1.
  - Collect-buffer contents are don't-care.
- Reset asserted mid-group or with a word held: everything returns to reset values immediately (asynchronous). A held word is lost.

## Timing

- Latency: closing sample accepted at edge t; `OUT_VLD` = 1 and data valid immediately after edge t.
- Sustained throughput with `OUT_RDY` = 1: one sample per cycle in, one word per `LANES` cycles out, no bubbles.
- Stall: a closing sample offered while a word is held is not accepted. It is accepted on the edge where `OUT_RDY` = 1, and the new word replaces the old one on that same edge.
- `IN_RDY` is combinational from `START`, `OUT_VLD`, `OUT_RDY` and `cnt`. There is no combinational path from `IN_VLD`, `DR` or `DI` to any output.
- `OUT_GRP` wraps from 2^GW-1 to 0 with no flag.

## Test plan

- **Natural order.** Setup: `LANES`=4, `NB`=16, `BR`=0, `OUT_RDY`=1. Stimulus: samples DR=1,2,3,4 and DI=5,6,7,8 on consecutive cycles. Required: one cycle after sample 4, `OR`=0x0004_0003_0002_0001, `OI`=0x0008_0007_0006_0005, `OUT_GRP`=0, with `OUT_VLD` high for exactly one cycle.
- **Bit-reversed order.** Stimulus: `BR`=1 at sample 0, DR=1,2,3,4; `BR` toggles to 0 mid-group. Required: `OR`=0x0004_0002_0003_0001.
- **Back-pressure.** Stimulus: hold `OUT_RDY`=0 after group 0 completes; stream 8 samples. Required:
  - Samples 4..6 are accepted; `IN_RDY`=0 while sample 7 is offered.
  - Group 0 data stays stable.
  - When `OUT_RDY` rises, sample 7 is accepted that edge and group 1 appears next cycle with `OUT_GRP`=1.
- **START mid-group.** Stimulus: after 2 samples, pulse `START` together with DR=9, then DR=10,11,12. Required: `OR`=0x000C_000B_000A_0009, `OUT_GRP`=0.
- **Reset mid-operation.** Stimulus: drop `RST` with a word held and `cnt`=2. Required: `OUT_VLD`=0, `OR`/`OI`=0 and `IN_RDY`=1 immediately. The next 4 samples form group 0.
- **Counter wrap and corner width.** Setup: `GW`=2, `LANES`=32. Stimulus: 5 full groups. Required: `OUT_GRP` sequence 0,1,2,3,0. Lane 31 holds the last sample in natural order and bitrev(31)=31 in bit-reversed order.

Source files
------------

// File: rtl/fft_se2pa_stream_if.sv
// Stream bundle between the FFT sample source, the serial-to-parallel front end
// and the radix engine. The slave modport is the converter's view.
interface fft_se2pa_stream_if #(
   parameter int NB    = 16,
   parameter int LANES = 4,
   parameter int GW    = 8
);
   logic                start;
   logic                br;
   logic                in_vld;
   logic                in_rdy;
   logic [NB-1:0]       dr;
   logic [NB-1:0]       di;
   logic                out_vld;
   logic                out_rdy;
   logic [NB*LANES-1:0] out_r;
   logic [NB*LANES-1:0] out_i;
   logic [GW-1:0]       out_grp;

   modport master (
      output start, br, in_vld, dr, di, out_rdy,
      input  in_rdy, out_vld, out_r, out_i, out_grp
   );

   modport slave (
      input  start, br, in_vld, dr, di, out_rdy,
      output in_rdy, out_vld, out_r, out_i, out_grp
   );
endinterface

// File: rtl/fft_se2pa_stream.sv
// Serial-to-parallel front end of the pipelined FFT: packs LANES consecutive
// complex samples into one wide word, in natural or bit-reversed lane order.
module fft_se2pa_stream #(
   parameter int NB    = 16,
   parameter int LANES = 4,
   parameter int GW    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   fft_se2pa_stream_if.slave bus
);

   localparam int            CW   = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [CW-1:0] LAST = CW'(LANES - 1);

   typedef enum logic {
      OUT_EMPTY,
      OUT_HELD
   } out_state_t;

   out_state_t          state;
   out_state_t          state_nxt;

   logic [CW-1:0]       cnt;
   logic [CW-1:0]       cnt_eff;
   logic [CW-1:0]       lane;
   logic [GW-1:0]       grp;
   logic [GW-1:0]       grp_eff;
   logic                br_hold;
   logic                mode;
   logic                in_rdy;
   logic                accept;
   logic                closing;

   logic [NB-1:0]       buf_r [LANES];
   logic [NB-1:0]       buf_i [LANES];
   logic [NB*LANES-1:0] word_r;
   logic [NB*LANES-1:0] word_i;
   logic [NB*LANES-1:0] out_r_q;
   logic [NB*LANES-1:0] out_i_q;
   logic [GW-1:0]       out_grp_q;

   function automatic logic [CW-1:0] bitrev(input logic [CW-1:0] k);
      logic [CW-1:0] r;
      r = '0;
      for (int b = 0; b < CW; b++) begin
         r[b] = k[CW-1-b];
      end
      return r;
   endfunction

   // START restarts the group in the same cycle, so its sample is sample 0 of the new group
   always_comb begin
      cnt_eff = bus.start ? '0 : cnt;
      grp_eff = bus.start ? '0 : grp;
      mode    = (cnt_eff == '0) ? bus.br : br_hold;
      lane    = mode ? bitrev(cnt_eff) : cnt_eff;
      in_rdy  = bus.start | ~((cnt == LAST) && (state == OUT_HELD) && !bus.out_rdy);
      accept  = bus.in_vld && in_rdy;
      closing = accept && (cnt_eff == LAST);
   end

   // The closing sample always maps to the top lane, so it bypasses the buffer
   always_comb begin
      word_r = '0;
      word_i = '0;
      for (int j = 0; j < LANES; j++) begin
         word_r[NB*j +: NB] = (lane == CW'(j)) ? bus.dr : buf_r[j];
         word_i[NB*j +: NB] = (lane == CW'(j)) ? bus.di : buf_i[j];
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         OUT_EMPTY: if (closing) state_nxt = OUT_HELD;
         OUT_HELD:  if (!closing && bus.out_rdy) state_nxt = OUT_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= OUT_EMPTY;
         cnt       <= '0;
         grp       <= '0;
         br_hold   <= 1'b0;
         out_r_q   <= '0;
         out_i_q   <= '0;
         out_grp_q <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= accept ? cnt_eff + 1'b1 : cnt_eff;
         grp   <= closing ? grp_eff + 1'b1 : grp_eff;
         if (accept && (cnt_eff == '0)) begin
            br_hold <= bus.br;
         end
         if (closing) begin
            out_r_q   <= word_r;
            out_i_q   <= word_i;
            out_grp_q <= grp_eff;
         end
      end
   end

   // Collect buffer contents are only meaningful after being written, so no reset
   always_ff @(posedge clk) begin
      if (accept && !closing) begin
         buf_r[lane] <= bus.dr;
         buf_i[lane] <= bus.di;
      end
   end

   assign bus.in_rdy  = in_rdy;
   assign bus.out_vld = (state == OUT_HELD);
   assign bus.out_r   = out_r_q;
   assign bus.out_i   = out_i_q;
   assign bus.out_grp = out_grp_q;

endmodule

// File: tb/tb_fft_se2pa_stream.sv
// Directed bench for fft_se2pa_stream: a 4-lane instance for ordering, stall,
// START and reset behaviour, and a 32-lane/GW=2 instance for wrap and corner width.
module tb_fft_se2pa_stream;

   logic clk;
   logic rst_n;
   int   testsRun  = 0;
   int   failCount = 0;
   int   grpSeq [5] = '{0, 1, 2, 3, 0};
   logic gBr;
   logic [511:0] expR;
   logic [511:0] expI;

   fft_se2pa_stream_if #(.NB(16), .LANES(4),  .GW(8)) bus4 ();
   fft_se2pa_stream_if #(.NB(16), .LANES(32), .GW(2)) bus32 ();

   fft_se2pa_stream #(.NB(16), .LANES(4), .GW(8)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   fft_se2pa_stream #(.NB(16), .LANES(32), .GW(2)) u_dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic s, input logic b, input logic v,
                                input logic [15:0] r, input logic [15:0] i);
      bus4.start  = s;
      bus4.br     = b;
      bus4.in_vld = v;
      bus4.dr     = r;
      bus4.di     = i;
      #1;
   endtask

   function automatic int rev5(input int j);
      logic [4:0] x;
      logic [4:0] y;
      x = 5'(j);
      y = {<<{x}};
      return int'(y);
   endfunction

   initial begin
      rst_n         = 1'b0;
      bus4.start    = 1'b0;
      bus4.br       = 1'b0;
      bus4.in_vld   = 1'b0;
      bus4.dr       = '0;
      bus4.di       = '0;
      bus4.out_rdy  = 1'b1;
      bus32.start   = 1'b0;
      bus32.br      = 1'b0;
      bus32.in_vld  = 1'b0;
      bus32.dr      = '0;
      bus32.di      = '0;
      bus32.out_rdy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_vld",   512'(bus4.out_vld), 512'(0));
      checkOutput("rst_r",     512'(bus4.out_r),   512'(0));
      checkOutput("rst_i",     512'(bus4.out_i),   512'(0));
      checkOutput("rst_grp",   512'(bus4.out_grp), 512'(0));
      checkOutput("rst_inrdy", 512'(bus4.in_rdy),  512'(1));
      rst_n = 1'b1;
      tick();

      // Natural order
      applyStimulus(0, 0, 1, 16'd1, 16'd5); tick();
      applyStimulus(0, 0, 1, 16'd2, 16'd6); tick();
      applyStimulus(0, 0, 1, 16'd3, 16'd7); tick();
      checkOutput("nat_vld_early", 512'(bus4.out_vld), 512'(0));
      applyStimulus(0, 0, 1, 16'd4, 16'd8); tick();
      checkOutput("nat_vld", 512'(bus4.out_vld), 512'(1));
      checkOutput("nat_r",   512'(bus4.out_r),   512'(64'h0004_0003_0002_0001));
      checkOutput("nat_i",   512'(bus4.out_i),   512'(64'h0008_0007_0006_0005));
      checkOutput("nat_grp", 512'(bus4.out_grp), 512'(0));
      applyStimulus(0, 0, 0, 16'd0, 16'd0); tick();
      checkOutput("nat_vld_drop", 512'(bus4.out_vld), 512'(0));

      // Bit-reversed order, BR toggled mid-group must be ignored
      applyStimulus(0, 1, 1, 16'd1, 16'd0); tick();
      applyStimulus(0, 0, 1, 16'd2, 16'd0); tick();
      applyStimulus(0, 0, 1, 16'd3, 16'd0); tick();
      applyStimulus(0, 0, 1, 16'd4, 16'd0); tick();
      checkOutput("br_r",   512'(bus4.out_r),   512'(64'h0004_0002_0003_0001));
      checkOutput("br_grp", 512'(bus4.out_grp), 512'(1));
      applyStimulus(0, 0, 0, 16'd0, 16'd0); tick();

      // Back-pressure
      applyStimulus(1, 0, 0, 16'd0, 16'd0); tick();
      bus4.out_rdy = 1'b0;
      applyStimulus(0, 0, 1, 16'h11, 16'h21); tick();
      applyStimulus(0, 0, 1, 16'h12, 16'h22); tick();
      applyStimulus(0, 0, 1, 16'h13, 16'h23); tick();
      applyStimulus(0, 0, 1, 16'h14, 16'h24); tick();
      checkOutput("bp_g0_vld", 512'(bus4.out_vld), 512'(1));
      checkOutput("bp_g0_r",   512'(bus4.out_r),   512'(64'h0014_0013_0012_0011));
      checkOutput("bp_g0_grp", 512'(bus4.out_grp), 512'(0));
      applyStimulus(0, 0, 1, 16'h15, 16'h25);
      checkOutput("bp_rdy_s4", 512'(bus4.in_rdy), 512'(1)); tick();
      applyStimulus(0, 0, 1, 16'h16, 16'h26);
      checkOutput("bp_rdy_s5", 512'(bus4.in_rdy), 512'(1)); tick();
      applyStimulus(0, 0, 1, 16'h17, 16'h27);
      checkOutput("bp_rdy_s6", 512'(bus4.in_rdy), 512'(1)); tick();
      applyStimulus(0, 0, 1, 16'h18, 16'h28);
      checkOutput("bp_stall1", 512'(bus4.in_rdy), 512'(0)); tick();
      checkOutput("bp_hold_r1", 512'(bus4.out_r),   512'(64'h0014_0013_0012_0011));
      checkOutput("bp_hold_g1", 512'(bus4.out_grp), 512'(0));
      checkOutput("bp_stall2", 512'(bus4.in_rdy), 512'(0)); tick();
      checkOutput("bp_hold_i2", 512'(bus4.out_i),   512'(64'h0024_0023_0022_0021));
      checkOutput("bp_hold_v2", 512'(bus4.out_vld), 512'(1));
      bus4.out_rdy = 1'b1;
      #1;
      checkOutput("bp_release", 512'(bus4.in_rdy), 512'(1)); tick();
      checkOutput("bp_g1_vld", 512'(bus4.out_vld), 512'(1));
      checkOutput("bp_g1_r",   512'(bus4.out_r),   512'(64'h0018_0017_0016_0015));
      checkOutput("bp_g1_i",   512'(bus4.out_i),   512'(64'h0028_0027_0026_0025));
      checkOutput("bp_g1_grp", 512'(bus4.out_grp), 512'(1));
      applyStimulus(0, 0, 0, 16'd0, 16'd0); tick();
      checkOutput("bp_vld_drop", 512'(bus4.out_vld), 512'(0));

      // START mid-group
      applyStimulus(0, 0, 1, 16'd7, 16'd0); tick();
      applyStimulus(0, 0, 1, 16'd8, 16'd0); tick();
      applyStimulus(1, 0, 1, 16'd9, 16'd0); tick();
      applyStimulus(0, 0, 1, 16'd10, 16'd0); tick();
      applyStimulus(0, 0, 1, 16'd11, 16'd0); tick();
      applyStimulus(0, 0, 1, 16'd12, 16'd0); tick();
      checkOutput("st_r",   512'(bus4.out_r),   512'(64'h000C_000B_000A_0009));
      checkOutput("st_grp", 512'(bus4.out_grp), 512'(0));
      applyStimulus(0, 0, 0, 16'd0, 16'd0); tick();

      // START overrides a stall and leaves the held word intact
      bus4.out_rdy = 1'b0;
      applyStimulus(0, 0, 1, 16'h51, 16'd0); tick();
      applyStimulus(0, 0, 1, 16'h52, 16'd0); tick();
      applyStimulus(0, 0, 1, 16'h53, 16'd0); tick();
      applyStimulus(0, 0, 1, 16'h54, 16'd0); tick();
      checkOutput("sh_grp", 512'(bus4.out_grp), 512'(1));
      applyStimulus(0, 0, 1, 16'h55, 16'd0); tick();
      applyStimulus(0, 0, 1, 16'h56, 16'd0); tick();
      applyStimulus(0, 0, 1, 16'h57, 16'd0); tick();
      applyStimulus(0, 0, 1, 16'h58, 16'd0);
      checkOutput("sh_stall", 512'(bus4.in_rdy), 512'(0));
      applyStimulus(1, 0, 1, 16'h58, 16'd0);
      checkOutput("sh_start_rdy", 512'(bus4.in_rdy), 512'(1)); tick();
      checkOutput("sh_keep_r",   512'(bus4.out_r),   512'(64'h0054_0053_0052_0051));
      checkOutput("sh_keep_vld", 512'(bus4.out_vld), 512'(1));
      applyStimulus(0, 0, 1, 16'h59, 16'd0); tick();

      // Reset with a word held and two samples collected
      applyStimulus(0, 0, 0, 16'd0, 16'd0);
      rst_n = 1'b0;
      #1;
      checkOutput("mr_vld",   512'(bus4.out_vld), 512'(0));
      checkOutput("mr_r",     512'(bus4.out_r),   512'(0));
      checkOutput("mr_i",     512'(bus4.out_i),   512'(0));
      checkOutput("mr_inrdy", 512'(bus4.in_rdy),  512'(1));
      checkOutput("mr_grp",   512'(bus4.out_grp), 512'(0));
      rst_n = 1'b1;
      bus4.out_rdy = 1'b1;
      tick();
      applyStimulus(0, 0, 1, 16'h31, 16'h41); tick();
      applyStimulus(0, 0, 1, 16'h32, 16'h42); tick();
      applyStimulus(0, 0, 1, 16'h33, 16'h43); tick();
      applyStimulus(0, 0, 1, 16'h34, 16'h44); tick();
      checkOutput("ar_vld", 512'(bus4.out_vld), 512'(1));
      checkOutput("ar_r",   512'(bus4.out_r),   512'(64'h0034_0033_0032_0031));
      checkOutput("ar_grp", 512'(bus4.out_grp), 512'(0));
      applyStimulus(0, 0, 0, 16'd0, 16'd0); tick();

      // 32 lanes, 2-bit group counter: five groups, groups 1 and 4 bit-reversed
      for (int g = 0; g < 5; g++) begin
         gBr = (g == 1) || (g == 4);
         for (int k = 0; k < 32; k++) begin
            bus32.br     = (k == 0) ? gBr : 1'(k % 2);
            bus32.in_vld = 1'b1;
            bus32.dr     = 16'(g * 256 + k);
            bus32.di     = 16'(32'h8000 + g * 256 + k);
            #1;
            checkOutput("w_inrdy", 512'(bus32.in_rdy), 512'(1));
            tick();
         end
         expR = '0;
         expI = '0;
         for (int j = 0; j < 32; j++) begin
            expR[16*j +: 16] = 16'(g * 256 + (gBr ? rev5(j) : j));
            expI[16*j +: 16] = 16'(32'h8000 + g * 256 + (gBr ? rev5(j) : j));
         end
         checkOutput("w_vld",    512'(bus32.out_vld),          512'(1));
         checkOutput("w_grp",    512'(bus32.out_grp),          512'(grpSeq[g]));
         checkOutput("w_lane31", 512'(bus32.out_r[511:496]),   512'(16'(g * 256 + 31)));
         checkOutput("w_r",      bus32.out_r,                  expR);
         checkOutput("w_i",      bus32.out_i,                  expI);
      end
      bus32.in_vld = 1'b0;
      tick();
      checkOutput("w_vld_drop", 512'(bus32.out_vld), 512'(0));

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
